// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the vectored interrupt controller: register map,
// FSM state encoding and CTRL field positions.
package int_ctrl_pkg;

  localparam int unsigned NIrq = 8;
  localparam int unsigned IdW  = 3;

  localparam logic [1:0] AddrVecBase = 2'd0;
  localparam logic [1:0] AddrCtrl    = 2'd1;
  localparam logic [1:0] AddrPending = 2'd2;
  localparam logic [1:0] AddrStatus  = 2'd3;

  localparam int unsigned GieBit = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StFire    = 2'b01,
    StService = 2'b10
  } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first 8-to-3 priority encoder; bit 0 has the highest priority.
module int_prio_enc
  import int_ctrl_pkg::*;
(
  input  logic [NIrq-1:0] req_i,
  output logic [IdW-1:0]  id_o,
  output logic            valid_o
);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    id_o    = '0;
    valid_o = 1'b0;
    for (int i = NIrq - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        id_o    = IdW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Vectored interrupt controller: edge-latched sources, mask/GIE, one-cycle
// redirect to vec_base + 4*id, EPC capture, and blocking until end-of-interrupt.
module int_ctrl
  import int_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_flag,
  input  logic [7:0]  irq,
  input  logic [31:0] ret_pc,
  input  logic        eoi,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        int_flag,
  output logic [31:0] int_addr,
  output logic        busy
);

  state_e           state_q, state_d;
  logic [31:0]      vec_base_q, vec_base_d;
  logic [NIrq-1:0]  mask_q, mask_d;
  logic             gie_q, gie_d;
  logic [NIrq-1:0]  pending_q, pending_d;
  logic [31:0]      epc_q, epc_d;
  logic [NIrq-1:0]  irq_d_q;
  logic [IdW-1:0]   isr_id_q, isr_id_d;
  logic             int_flag_q, int_flag_d;
  logic [31:0]      int_addr_q, int_addr_d;

  logic [NIrq-1:0]  elig;
  logic [IdW-1:0]   elig_id;
  logic             elig_valid;
  logic [NIrq-1:0]  clr;
  logic             cfg_wr;

  assign elig   = pending_q & mask_q;
  assign cfg_wr = ~cfg_we;

  int_prio_enc u_prio_enc (
    .req_i   (elig),
    .id_o    (elig_id),
    .valid_o (elig_valid)
  );

  always_comb begin
    state_d    = state_q;
    vec_base_d = vec_base_q;
    mask_d     = mask_q;
    gie_d      = gie_q;
    epc_d      = epc_q;
    isr_id_d   = isr_id_q;
    int_flag_d = int_flag_q;
    int_addr_d = int_addr_q;
    clr        = '0;

    if (cfg_wr) begin
      case (cfg_addr)
        AddrVecBase: vec_base_d = cfg_wdata;
        AddrCtrl: begin
          mask_d = cfg_wdata[NIrq-1:0];
          gie_d  = cfg_wdata[GieBit];
        end
        AddrPending: clr = cfg_wdata[NIrq-1:0];
        default: ;
      endcase
    end

    // Decisions use registered MASK/GIE/VEC_BASE, so same-cycle writes land afterwards.
    case (state_q)
      StIdle: begin
        if (gie_q && elig_valid) begin
          state_d    = StFire;
          int_addr_d = vec_base_q + {27'b0, elig_id, 2'b00};
          isr_id_d   = elig_id;
          int_flag_d = 1'b0;
        end
      end
      StFire: begin
        epc_d         = ret_pc;
        clr[isr_id_q] = 1'b1;
        int_flag_d    = 1'b1;
        state_d       = StService;
      end
      StService: begin
        if (!eoi) state_d = StIdle;
      end
      default: begin
        state_d    = StIdle;
        int_flag_d = 1'b1;
      end
    endcase

    // New edges win over any clear landing on the same bit.
    pending_d = (pending_q & ~clr) | (irq & ~irq_d_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_flag) begin
      state_q    <= StIdle;
      vec_base_q <= '0;
      mask_q     <= '0;
      gie_q      <= 1'b0;
      pending_q  <= '0;
      epc_q      <= '0;
      irq_d_q    <= '0;
      isr_id_q   <= '0;
      int_flag_q <= 1'b1;
      int_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      vec_base_q <= vec_base_d;
      mask_q     <= mask_d;
      gie_q      <= gie_d;
      pending_q  <= pending_d;
      epc_q      <= epc_d;
      irq_d_q    <= irq;
      isr_id_q   <= isr_id_d;
      int_flag_q <= int_flag_d;
      int_addr_q <= int_addr_d;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      AddrVecBase: cfg_rdata = vec_base_q;
      AddrCtrl:    cfg_rdata = {23'b0, gie_q, mask_q};
      AddrPending: cfg_rdata = {24'b0, pending_q};
      AddrStatus:  cfg_rdata = epc_q;
      default:     cfg_rdata = '0;
    endcase
  end

  assign int_flag = int_flag_q;
  assign int_addr = int_addr_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst_flag = 1'b0;
  logic [7:0]  irq = '0;
  logic [31:0] ret_pc = '0;
  logic        eoi = 1'b1;
  logic        cfg_we = 1'b1;
  logic [1:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata;
  logic        int_flag;
  logic [31:0] int_addr;
  logic        busy;

  int n_vec = 0;
  int n_miss = 0;

  int_ctrl dut (
    .clk       (clk),
    .rst_flag  (rst_flag),
    .irq       (irq),
    .ret_pc    (ret_pc),
    .eoi       (eoi),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .int_flag  (int_flag),
    .int_addr  (int_addr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: "firing" is the single redirect cycle, "serving" waits for eoi.
  logic [31:0] m_base, m_epc, m_addr;
  logic [7:0]  m_pend, m_mask, m_prev_irq;
  logic        m_gie, m_flag, m_firing, m_serving;
  int          m_isr;

  function automatic logic [31:0] model_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return m_base;
      2'd1:    return {23'b0, m_gie, m_mask};
      2'd2:    return {24'b0, m_pend};
      default: return m_epc;
    endcase
  endfunction

  task automatic model_edge();
    logic [7:0] clr, rise, elig;
    int id;
    if (!rst_flag) begin
      m_base = 0; m_epc = 0; m_addr = 0; m_pend = 0; m_mask = 0; m_prev_irq = 0;
      m_gie = 0; m_flag = 1; m_firing = 0; m_serving = 0; m_isr = 0;
      return;
    end
    rise = irq & ~m_prev_irq;
    clr  = 0;
    elig = m_pend & m_mask;
    if (m_firing) begin
      clr[m_isr] = 1'b1;
      m_epc      = ret_pc;
      m_flag     = 1;
      m_firing   = 0;
      m_serving  = 1;
    end else if (m_serving) begin
      if (!eoi) m_serving = 0;
    end else if (m_gie && elig != 0) begin
      id = 0;
      while (!elig[id]) id++;
      m_addr   = m_base + 32'(4 * id);
      m_isr    = id;
      m_flag   = 0;
      m_firing = 1;
    end
    if (!cfg_we) begin
      case (cfg_addr)
        2'd0: m_base = cfg_wdata;
        2'd1: begin m_mask = cfg_wdata[7:0]; m_gie = cfg_wdata[8]; end
        2'd2: clr = clr | cfg_wdata[7:0];
        default: ;
      endcase
    end
    m_pend     = (m_pend & ~clr) | rise;
    m_prev_irq = irq;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b0; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b1;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b0;
    step();
    eoi = 1'b1;
  endtask

  task automatic test_reset();
    rst_flag = 1'b0;
    step(); step();
    rst_flag = 1'b1;
    n_vec++; if (int_flag !== 1'b1) begin n_miss++; $display("FAIL reset_flag got %b want 1", int_flag); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (int_addr !== 32'h0) begin n_miss++; $display("FAIL reset_addr got %h want 0", int_addr); end
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a); #1;
      n_vec++;
      if (cfg_rdata !== 32'h0) begin
        n_miss++; $display("FAIL reset_reg%0d got %h want 0", a, cfg_rdata);
      end
    end
  endtask

  task automatic test_basic();
    cfg_write(2'd0, 32'h100);
    cfg_write(2'd1, 32'h1FF);
    irq = 8'h08; step(); irq = 8'h00;
    cfg_addr = 2'd2; #1;
    n_vec++; if (cfg_rdata !== 32'h08) begin n_miss++; $display("FAIL basic_pend_e0 got %h want 08", cfg_rdata); end
    n_vec++; if (int_flag !== 1'b1) begin n_miss++; $display("FAIL basic_flag_e0 got %b want 1", int_flag); end
    step();
    n_vec++; if (int_flag !== 1'b0) begin n_miss++; $display("FAIL basic_flag_e1 got %b want 0", int_flag); end
    n_vec++; if (int_addr !== 32'h10C) begin n_miss++; $display("FAIL basic_addr got %h want 10c", int_addr); end
    ret_pc = 32'h2004; step();
    n_vec++; if (int_flag !== 1'b1) begin n_miss++; $display("FAIL basic_flag_e2 got %b want 1", int_flag); end
    n_vec++; if (busy !== 1'b1) begin n_miss++; $display("FAIL basic_busy got %b want 1", busy); end
    n_vec++; if (cfg_rdata !== 32'h0) begin n_miss++; $display("FAIL basic_pend_clr got %h want 0", cfg_rdata); end
    cfg_addr = 2'd3; #1;
    n_vec++; if (cfg_rdata !== 32'h2004) begin n_miss++; $display("FAIL basic_epc got %h want 2004", cfg_rdata); end
    pulse_eoi();
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL basic_eoi_busy got %b want 0", busy); end
  endtask

  task automatic test_two_sources();
    irq = 8'h24; step(); irq = 8'h00;
    step();
    n_vec++; if (int_addr !== 32'h108) begin n_miss++; $display("FAIL two_first_addr got %h want 108", int_addr); end
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (busy !== 1'b1 || int_flag !== 1'b1) begin
        n_miss++; $display("FAIL two_hold busy=%b flag=%b want busy=1 flag=1", busy, int_flag);
      end
    end
    pulse_eoi();
    n_vec++; if (int_flag !== 1'b1) begin n_miss++; $display("FAIL two_no_b2b got %b want 1", int_flag); end
    step();
    n_vec++; if (int_flag !== 1'b0) begin n_miss++; $display("FAIL two_second_flag got %b want 0", int_flag); end
    n_vec++; if (int_addr !== 32'h114) begin n_miss++; $display("FAIL two_second_addr got %h want 114", int_addr); end
    step(); pulse_eoi();
  endtask

  task automatic test_mask();
    cfg_write(2'd1, 32'h1EF);
    irq = 8'h10; step(); irq = 8'h00; step();
    cfg_addr = 2'd2; #1;
    n_vec++; if (cfg_rdata !== 32'h10) begin n_miss++; $display("FAIL mask_pend got %h want 10", cfg_rdata); end
    n_vec++; if (int_flag !== 1'b1) begin n_miss++; $display("FAIL mask_nofire got %b want 1", int_flag); end
    cfg_write(2'd1, 32'h1FF);
    n_vec++; if (int_flag !== 1'b1) begin n_miss++; $display("FAIL mask_prewrite got %b want 1", int_flag); end
    step();
    n_vec++; if (int_flag !== 1'b0) begin n_miss++; $display("FAIL mask_fire got %b want 0", int_flag); end
    n_vec++; if (int_addr !== 32'h110) begin n_miss++; $display("FAIL mask_addr got %h want 110", int_addr); end
    step(); pulse_eoi();
  endtask

  task automatic test_held_irq();
    cfg_write(2'd1, 32'h0FF);
    irq = 8'h40;
    repeat (10) step();
    cfg_addr = 2'd2; #1;
    n_vec++; if (cfg_rdata !== 32'h40) begin n_miss++; $display("FAIL held_pend got %h want 40", cfg_rdata); end
    cfg_write(2'd2, 32'h40);
    cfg_addr = 2'd2; #1;
    n_vec++; if (cfg_rdata !== 32'h0) begin n_miss++; $display("FAIL held_once got %h want 0", cfg_rdata); end
    irq = 8'h00; step();
  endtask

  task automatic test_w1c_collision();
    irq = 8'h02;
    cfg_write(2'd2, 32'h02);
    irq = 8'h00;
    cfg_addr = 2'd2; #1;
    n_vec++; if (cfg_rdata !== 32'h02) begin n_miss++; $display("FAIL w1c_setwins got %h want 02", cfg_rdata); end
    cfg_write(2'd2, 32'h02);
    cfg_addr = 2'd2; #1;
    n_vec++; if (cfg_rdata !== 32'h0) begin n_miss++; $display("FAIL w1c_clear got %h want 0", cfg_rdata); end
  endtask

  task automatic test_wrap();
    cfg_write(2'd0, 32'hFFFF_FFF8);
    cfg_write(2'd1, 32'h1FF);
    irq = 8'h08; step(); irq = 8'h00; step();
    n_vec++; if (int_addr !== 32'h4) begin n_miss++; $display("FAIL wrap_addr got %h want 00000004", int_addr); end
    step(); pulse_eoi();
  endtask

  task automatic test_reset_mid();
    cfg_write(2'd0, 32'h200);
    cfg_write(2'd1, 32'h1FF);
    irq = 8'h01; step(); irq = 8'h00; step();
    ret_pc = 32'hABC; step();
    rst_flag = 1'b0; step(); rst_flag = 1'b1;
    n_vec++; if (busy !== 1'b0 || int_flag !== 1'b1) begin
      n_miss++; $display("FAIL rst_svc busy=%b flag=%b want busy=0 flag=1", busy, int_flag);
    end
    cfg_addr = 2'd3; #1;
    n_vec++; if (cfg_rdata !== 32'h0) begin n_miss++; $display("FAIL rst_svc_epc got %h want 0", cfg_rdata); end
    cfg_write(2'd0, 32'h300);
    cfg_write(2'd1, 32'h1FF);
    irq = 8'h02; step(); irq = 8'h00; step();
    n_vec++; if (int_flag !== 1'b0) begin n_miss++; $display("FAIL rst_pre_fire got %b want 0", int_flag); end
    rst_flag = 1'b0; irq = 8'h80; ret_pc = 32'h55; step(); rst_flag = 1'b1; irq = 8'h00;
    n_vec++; if (busy !== 1'b0 || int_flag !== 1'b1) begin
      n_miss++; $display("FAIL rst_fire busy=%b flag=%b want busy=0 flag=1", busy, int_flag);
    end
    cfg_addr = 2'd2; #1;
    n_vec++; if (cfg_rdata !== 32'h0) begin n_miss++; $display("FAIL rst_fire_pend got %h want 0", cfg_rdata); end
    cfg_addr = 2'd3; #1;
    n_vec++; if (cfg_rdata !== 32'h0) begin n_miss++; $display("FAIL rst_fire_epc got %h want 0", cfg_rdata); end
    pulse_eoi();
    n_vec++; if (busy !== 1'b0 || int_flag !== 1'b1) begin
      n_miss++; $display("FAIL idle_eoi busy=%b flag=%b want busy=0 flag=1", busy, int_flag);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_rd;
    cfg_write(2'd0, $urandom);
    cfg_write(2'd1, 32'h1FF);
    for (int c = 0; c < 2000; c++) begin
      irq      = irq ^ 8'($urandom & $urandom & $urandom);
      eoi      = ($urandom_range(0, 5) != 0);
      rst_flag = ($urandom_range(0, 99) != 0);
      ret_pc   = $urandom;
      cfg_addr = 2'($urandom);
      cfg_we   = ($urandom_range(0, 7) != 0);
      cfg_wdata = (cfg_addr == 2'd1) ? ($urandom | 32'h100) & 32'h1FF : $urandom;
      step();
      exp_rd = model_rdata(cfg_addr);
      n_vec++; if (int_flag !== m_flag) begin n_miss++; $display("FAIL rnd_flag c=%0d got %b want %b", c, int_flag, m_flag); end
      n_vec++; if (int_addr !== m_addr) begin n_miss++; $display("FAIL rnd_addr c=%0d got %h want %h", c, int_addr, m_addr); end
      n_vec++; if (busy !== (m_firing | m_serving)) begin
        n_miss++; $display("FAIL rnd_busy c=%0d got %b want %b", c, busy, m_firing | m_serving);
      end
      n_vec++; if (cfg_rdata !== exp_rd) begin
        n_miss++; $display("FAIL rnd_rdata c=%0d addr=%0d got %h want %h", c, cfg_addr, cfg_rdata, exp_rd);
      end
    end
    cfg_we = 1'b1; eoi = 1'b1; rst_flag = 1'b1; irq = 8'h00;
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_two_sources();
    test_mask();
    test_held_irq();
    test_w1c_collision();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before bench completion");
    $fatal(1);
  end

endmodule
